// File: rtl/shiftreg_piso_tx.sv
// Parallel-in, serial-out transmitter: takes a word on a valid/ready handshake
// and streams it out one bit per clock, with a strobe on the first bit of each frame.
module shiftreg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_sof
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;

  // The register always shifts toward the MSB, so LSB-first words are
  // reversed on the way in rather than shifting the other direction.
  if (MSB_FIRST) begin : g_msb
    assign load_word = load_data;
  end else begin : g_lsb
    always_comb begin
      load_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
        load_word[i] = load_data[WIDTH-1-i];
      end
    end
  end

  assign load_ready = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = load_word;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          cnt_nxt  = cnt + CW'(1);
        end else if (accept) begin
          // Reloading on the last bit keeps consecutive frames gapless.
          sreg_nxt = load_word;
          cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so the first bit
  // appears in the cycle right after the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      dout       <= (state_nxt == SHIFT) && sreg_nxt[WIDTH-1];
      dout_valid <= (state_nxt == SHIFT);
      dout_sof   <= (state_nxt == SHIFT) && (cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_shiftreg_piso_tx.sv
// Directed bench for shiftreg_piso_tx: three instances (4-bit MSB-first,
// 4-bit LSB-first, 8-bit MSB-first) driven from a table of cycle vectors.
module tb_shiftreg_piso_tx;

  logic clk = 1'b0;
  logic rst;

  logic       lv4, rdy4, do4, dv4, sof4;
  logic [3:0] ld4;
  logic       lvl, rdyl, dol, dvl, sofl;
  logic [3:0] ldl;
  logic       lv8, rdy8, do8, dv8, sof8;
  logic [7:0] ld8;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  shiftreg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_w4 (
    .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
    .load_ready(rdy4), .dout(do4), .dout_valid(dv4), .dout_sof(sof4)
  );

  shiftreg_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lvl), .load_data(ldl),
    .load_ready(rdyl), .dout(dol), .dout_valid(dvl), .dout_sof(sofl)
  );

  shiftreg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_w8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8),
    .load_ready(rdy8), .dout(do8), .dout_valid(dv8), .dout_sof(sof8)
  );

  // One record per clock cycle: inputs for the cycle, load_ready expected in
  // that cycle, and the registered outputs expected in the following cycle.
  typedef struct {
    int         sel;
    logic       rst;
    logic       lv;
    logic [7:0] data;
    logic       ready;
    logic       dout;
    logic       valid;
    logic       sof;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int sel, input logic r, input logic lv, input logic [7:0] d,
                        input logic rdy, input logic o, input logic v, input logic s);
    vec_t t;
    t.sel = sel; t.rst = r; t.lv = lv; t.data = d;
    t.ready = rdy; t.dout = o; t.valid = v; t.sof = s;
    vecs.push_back(t);
  endtask

  function automatic logic [3:0] getOuts(input int sel);
    case (sel)
      0:       return {rdy4, do4, dv4, sof4};
      1:       return {rdyl, dol, dvl, sofl};
      default: return {rdy8, do8, dv8, sof8};
    endcase
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    lv4 = 1'b0; lvl = 1'b0; lv8 = 1'b0;
    case (v.sel)
      0:       begin lv4 = v.lv; ld4 = v.data[3:0]; end
      1:       begin lvl = v.lv; ldl = v.data[3:0]; end
      default: begin lv8 = v.lv; ld8 = v.data;      end
    endcase
  endtask

  task automatic runVec(input vec_t v, input int idx);
    logic [3:0] o;
    applyStimulus(v);
    #1;
    o = getOuts(v.sel);
    checkOutput("load_ready", idx, {31'd0, o[3]}, {31'd0, v.ready});
    @(posedge clk);
    #1;
    o = getOuts(v.sel);
    checkOutput("dout",       idx, {31'd0, o[2]}, {31'd0, v.dout});
    checkOutput("dout_valid", idx, {31'd0, o[1]}, {31'd0, v.valid});
    checkOutput("dout_sof",   idx, {31'd0, o[0]}, {31'd0, v.sof});
  endtask

  initial begin
    int         waits;
    logic [3:0] got;

    // Single frame 1011, then idle.
    addVec(0, 0, 1, 8'h0B, 1, 1, 1, 1);
    addVec(0, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 1, 0, 0, 0);
    addVec(0, 0, 0, 8'h00, 1, 0, 0, 0);
    // Back-to-back 1011 then 0110 with load_valid held.
    addVec(0, 0, 1, 8'h0B, 1, 1, 1, 1);
    addVec(0, 0, 1, 8'h06, 0, 0, 1, 0);
    addVec(0, 0, 1, 8'h06, 0, 1, 1, 0);
    addVec(0, 0, 1, 8'h06, 0, 1, 1, 0);
    addVec(0, 0, 1, 8'h06, 1, 0, 1, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(0, 0, 0, 8'h00, 1, 0, 0, 0);
    // 1000 frame with F offered while busy; F only taken at the ready cycle.
    addVec(0, 0, 1, 8'h08, 1, 1, 1, 1);
    addVec(0, 0, 1, 8'h0F, 0, 0, 1, 0);
    addVec(0, 0, 1, 8'h0F, 0, 0, 1, 0);
    addVec(0, 0, 1, 8'h0F, 0, 0, 1, 0);
    addVec(0, 0, 1, 8'h0F, 1, 1, 1, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 1, 0, 0, 0);
    // Reset on the second bit of 1111 with load_valid on the same edge.
    addVec(0, 0, 1, 8'h0F, 1, 1, 1, 1);
    addVec(0, 1, 1, 8'h0F, 0, 0, 0, 0);
    addVec(0, 0, 0, 8'h0F, 1, 0, 0, 0);
    addVec(0, 0, 0, 8'h00, 1, 0, 0, 0);
    // load_data wiggling without a handshake does nothing.
    addVec(0, 0, 0, 8'h0F, 1, 0, 0, 0);
    addVec(0, 0, 0, 8'h05, 1, 0, 0, 0);
    // LSB-first: 1011 -> 1,1,0,1 and 0010 -> 0,1,0,0.
    addVec(1, 0, 1, 8'h0B, 1, 1, 1, 1);
    addVec(1, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(1, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(1, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(1, 0, 0, 8'h00, 1, 0, 0, 0);
    addVec(1, 0, 1, 8'h02, 1, 0, 1, 1);
    addVec(1, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(1, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(1, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(1, 0, 0, 8'h00, 1, 0, 0, 0);
    // WIDTH=8: A5 -> 1,0,1,0,0,1,0,1 with ready low for 7 cycles.
    addVec(2, 0, 1, 8'hA5, 1, 1, 1, 1);
    addVec(2, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 0, 1, 0);
    addVec(2, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(2, 0, 0, 8'h00, 1, 0, 0, 0);

    rst = 1'b1;
    lv4 = 1'b0; lvl = 1'b0; lv8 = 1'b0;
    ld4 = '0; ldl = '0; ld8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset dout",       -1, {31'd0, do4},  32'd0);
    checkOutput("reset dout_valid", -1, {31'd0, dv4},  32'd0);
    checkOutput("reset dout_sof",   -1, {31'd0, sof4}, 32'd0);
    checkOutput("reset load_ready", -1, {31'd0, rdy4}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i], i);
    end

    // Hand sequence: hold load_valid through a 0000 frame and count the busy
    // cycles before 1001 is taken, then collect its four bits.
    lv4 = 1'b1;
    ld4 = 4'b0000;
    @(posedge clk);
    #1;
    ld4 = 4'b1001;
    waits = 0;
    while (!rdy4 && waits < 8) begin
      @(posedge clk);
      #1;
      waits++;
    end
    checkOutput("busy cycles", 100, waits, 3);
    @(posedge clk);
    #1;
    lv4 = 1'b0;
    checkOutput("stream sof", 101, {31'd0, sof4}, 32'd1);
    got = {3'b000, do4};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      got = {got[2:0], do4};
    end
    checkOutput("stream word", 102, {28'd0, got}, 32'h9);
    @(posedge clk);
    #1;
    checkOutput("stream end valid", 103, {31'd0, dv4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/shiftreg_piso_tx.md
# shiftreg_piso_tx

Parallel-in, serial-out transmitter for the shift-register lab. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `dout`. A framing strobe marks the first bit so that a serial-in shift-register receiver can re-assemble words. Back-to-back words are streamed with no idle cycle between them.

## Interface
- `WIDTH`, default 4: word length in bits. Legal values are 2 to 32.
- `MSB_FIRST`, default 1: 1 sends `load_data[WIDTH-1]` first; 0 sends `load_data[0]` first.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load_valid`, input, 1: `load_data` is offered this cycle.
- `load_data`, input, WIDTH: word to transmit. Sampled only on a handshake.
- `load_ready`, output, 1: transmitter can accept a word this cycle.
- `dout`, output, 1: serial data, registered.
- `dout_valid`, output, 1: `dout` carries a frame bit this cycle, registered.
- `dout_sof`, output, 1: `dout` carries bit 0 of a frame, registered.

## Operation
- **State.**
  - WIDTH-bit shift register `sreg`.
  - Bit counter `cnt`, width clog2(WIDTH), counting 0..WIDTH-1.
  - FSM with two states, IDLE and SHIFT.
- **Handshake.** A word is accepted on a rising edge where `load_valid && load_ready` is sampled and `rst` is low.
- **`load_ready`** is combinational and equals `(state==IDLE) || (state==SHIFT && cnt==WIDTH-1)`. It never depends on `load_valid`.
- **IDLE → SHIFT** on handshake:
  - load `sreg` with `load_data`, bit-reversed when `MSB_FIRST=0` so the shift direction is always toward the MSB;
  - set `cnt` to 0.
- **SHIFT, `cnt < WIDTH-1`:**
  - shift `sreg` left by one, filling with 0;
  - increment `cnt`.
- **SHIFT, `cnt == WIDTH-1`:**
  - with a handshake: reload as above and stay in SHIFT (gapless streaming);
  - without a handshake: go to IDLE.
- **Outputs** are registered from the next-state values:
  - `dout` = `sreg[WIDTH-1]` when `dout_valid` is 1, else 0;
  - `dout_valid` = 1 whenever the state is SHIFT;
  - `dout_sof` = 1 when `cnt==0` in SHIFT.
- **`load_data` changes** while no handshake occurs have no effect.
- **Reset values:** state IDLE, `sreg`=0, `cnt`=0, `dout`=0, `dout_valid`=0, `dout_sof`=0. Consequently `load_ready`=1 in the first cycle after reset.
- **Reset mid-frame:** the frame is aborted with no partial completion. All outputs take their reset values in the cycle after the reset edge. A `load_valid` asserted on the same edge as `rst` is not accepted.

## Timing
- **Latency.** For a handshake at edge k:
  - first bit on `dout`, with `dout_valid`=1 and `dout_sof`=1, in the cycle after edge k;
  - last bit in the cycle after edge k+WIDTH-1;
  - frame occupies exactly WIDTH consecutive cycles.
- **Throughput:** one word per WIDTH cycles when `load_valid` is held high. There is no idle cycle between frames.
- **Busy window:** `load_ready` is 0 for WIDTH-1 cycles after each handshake, then 1 again during the last-bit cycle.
- **Isolated frame:** `dout_valid` falls in the cycle after the last bit.

## Test plan
1. **Single frame.** Reset, then WIDTH=4, MSB_FIRST=1, one handshake with `load_data`=4'b1011.
   - `dout` = 1,0,1,1 on four consecutive cycles.
   - `dout_valid`=1 for exactly those four cycles; `dout_sof`=1 only on the first.
   - `dout` and `dout_valid` are 0 afterwards.
2. **Back-to-back.** Hold `load_valid`=1 with 4'b1011, then 4'b0110, accepted at the ready cycle.
   - `dout` = 1,0,1,1,0,1,1,0 with `dout_valid` high for 8 consecutive cycles.
   - `dout_sof` pulses on cycles 1 and 5.
3. **Busy rejection.** Offer 4'hF while `load_ready`=0, midway through a 4'b1000 frame.
   - The frame completes as 1,0,0,0.
   - 4'hF is accepted only when `load_ready`=1; the next frame is 1,1,1,1.
4. **LSB-first.** MSB_FIRST=0 with `load_data`=4'b1011 gives `dout` = 1,1,0,1.
5. **Reset mid-frame.** Assert `rst` on the 2nd bit of 4'b1111 with `load_valid`=1 on the same edge.
   - Next cycle: `dout`=0, `dout_valid`=0, `dout_sof`=0, `load_ready`=1.
   - No word is accepted on that edge.
6. **WIDTH=8 frame.** 8'hA5 sent MSB-first gives 1,0,1,0,0,1,0,1 over 8 cycles, with `load_ready` low for 7 of them.
